// File: rtl/velocity_resolver.sv
// velocity_resolver: speed/pitch/heading to Cartesian Q16.16 velocity.
// One shared multiplier and a quarter-wave sine ROM, sequenced by a fixed FSM.
module velocity_resolver #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int LUT_WIDTH  = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  request_velocities,
    output logic                  velocities_ready,
    output logic                  busy,
    input  logic [DATA_WIDTH-1:0] speed,
    input  logic [DATA_WIDTH-1:0] pitch,
    input  logic [DATA_WIDTH-1:0] heading,
    output logic [DATA_WIDTH-1:0] v_x,
    output logic [DATA_WIDTH-1:0] v_y,
    output logic [DATA_WIDTH-1:0] v_z
);

    localparam int INT_BITS = DATA_WIDTH - FRAC_BITS;
    localparam int PROD_W   = 2 * DATA_WIDTH;
    localparam logic signed [INT_BITS-1:0] FULL_TURN = 360;

    localparam int SIN_ROM [0:90] = '{
        0, 1144, 2287, 3430, 4572, 5712, 6850, 7987, 9121, 10252,
        11380, 12505, 13626, 14742, 15855, 16962, 18064, 19161, 20252, 21336,
        22415, 23486, 24550, 25607, 26656, 27697, 28729, 29753, 30767, 31772,
        32768, 33754, 34729, 35693, 36647, 37590, 38521, 39441, 40348, 41243,
        42126, 42995, 43852, 44695, 45525, 46341, 47143, 47930, 48703, 49461,
        50203, 50931, 51643, 52339, 53020, 53684, 54332, 54963, 55578, 56175,
        56756, 57319, 57865, 58393, 58903, 59396, 59870, 60326, 60764, 61183,
        61584, 61966, 62328, 62672, 62997, 63303, 63589, 63856, 64104, 64332,
        64540, 64729, 64898, 65048, 65177, 65287, 65376, 65446, 65496, 65526,
        65536
    };

    typedef enum logic [2:0] {
        IDLE, LUT_P, LUT_H, MUL_H, MUL_Y, MUL_X, MUL_Z, DONE
    } state_t;

    state_t state, state_n;

    logic [DATA_WIDTH-1:0] speed_q;
    logic [8:0]            pitch_a, head_a;
    logic [DATA_WIDTH-1:0] sin_p, cos_p, sin_h, cos_h;
    logic [DATA_WIDTH-1:0] h, shadow_x, shadow_y;

    logic signed [DATA_WIDTH-1:0] op_a, op_b;
    logic signed [PROD_W-1:0]     prod;
    logic [DATA_WIDTH-1:0]        mul_q;

    // Single correction step: one add or subtract of a full turn.
    function automatic logic [8:0] wrap_angle(input logic [INT_BITS-1:0] a);
        logic signed [INT_BITS-1:0] i;
        logic signed [INT_BITS-1:0] w;
        i = $signed(a);
        if (i < 0)
            w = i + FULL_TURN;
        else if (i >= FULL_TURN)
            w = i - FULL_TURN;
        else
            w = i;
        return 9'(w);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sin_q(input logic [8:0] a);
        logic [8:0]            k;
        logic                  neg;
        logic [LUT_WIDTH-1:0]  mag;
        logic [DATA_WIDTH-1:0] m;
        neg = 1'b0;
        if (a <= 9'd90) begin
            k = a;
        end else if (a <= 9'd180) begin
            k = 9'd180 - a;
        end else if (a <= 9'd270) begin
            k   = a - 9'd180;
            neg = 1'b1;
        end else begin
            k   = 9'd360 - a;
            neg = 1'b1;
        end
        mag = (k <= 9'd90) ? LUT_WIDTH'(SIN_ROM[k[6:0]]) : '0;
        m   = {{(DATA_WIDTH-LUT_WIDTH){1'b0}}, mag};
        return neg ? -m : m;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] cos_q(input logic [8:0] a);
        logic [9:0] t;
        t = {1'b0, a} + 10'd90;
        if (t >= 10'd360)
            t = t - 10'd360;
        return sin_q(9'(t));
    endfunction

    always_comb begin
        op_a = $signed(speed_q);
        op_b = $signed(cos_p);
        case (state)
            MUL_Y: op_b = $signed(sin_p);
            MUL_X: begin
                op_a = $signed(h);
                op_b = $signed(sin_h);
            end
            MUL_Z: begin
                op_a = $signed(h);
                op_b = $signed(cos_h);
            end
            default: ;
        endcase
    end

    assign prod  = PROD_W'(op_a) * PROD_W'(op_b);
    assign mul_q = prod[FRAC_BITS +: DATA_WIDTH];

    logic unused_bits;
    assign unused_bits = ^{speed[DATA_WIDTH-1],
                           pitch[FRAC_BITS-1:0],
                           heading[FRAC_BITS-1:0],
                           prod[PROD_W-1:FRAC_BITS+DATA_WIDTH],
                           prod[FRAC_BITS-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n          = state;
        velocities_ready = 1'b0;
        busy             = 1'b0;
        case (state)
            IDLE:  if (request_velocities) state_n = LUT_P;
            LUT_P: state_n = LUT_H;
            LUT_H: state_n = MUL_H;
            MUL_H: state_n = MUL_Y;
            MUL_Y: state_n = MUL_X;
            MUL_X: state_n = MUL_Z;
            MUL_Z: state_n = request_velocities ? DONE : IDLE;
            DONE:  if (!request_velocities) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state == DONE)
            velocities_ready = 1'b1;
        if (state != IDLE && state != DONE)
            busy = 1'b1;
    end

    // Outputs move only on the MUL_Z edge; every other state works on internals.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed_q  <= '0;
            pitch_a  <= '0;
            head_a   <= '0;
            sin_p    <= '0;
            cos_p    <= '0;
            sin_h    <= '0;
            cos_h    <= '0;
            h        <= '0;
            shadow_x <= '0;
            shadow_y <= '0;
            v_x      <= '0;
            v_y      <= '0;
            v_z      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request_velocities) begin
                        speed_q <= {1'b0, speed[DATA_WIDTH-2:0]};
                        pitch_a <= wrap_angle(pitch[DATA_WIDTH-1:FRAC_BITS]);
                        head_a  <= wrap_angle(heading[DATA_WIDTH-1:FRAC_BITS]);
                    end
                end
                LUT_P: begin
                    sin_p <= sin_q(pitch_a);
                    cos_p <= cos_q(pitch_a);
                end
                LUT_H: begin
                    sin_h <= sin_q(head_a);
                    cos_h <= cos_q(head_a);
                end
                MUL_H: h        <= mul_q;
                MUL_Y: shadow_y <= mul_q;
                MUL_X: shadow_x <= mul_q;
                MUL_Z: begin
                    v_x <= shadow_x;
                    v_y <= shadow_y;
                    v_z <= -mul_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_velocity_resolver.sv
// tb_velocity_resolver: directed checks of velocity_resolver
// covering reset, latency, trig folding, angle wrap and abort.
module tb_velocity_resolver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [31:0] speed = '0;
    logic [31:0] pitch = '0;
    logic [31:0] heading = '0;
    logic        ready;
    logic        busy;
    logic [31:0] v_x, v_y, v_z;

    int compared = 0;
    int mismatched = 0;

    velocity_resolver dut (
        .clk                (clk),
        .reset              (reset),
        .request_velocities (req),
        .velocities_ready   (ready),
        .busy               (busy),
        .speed              (speed),
        .pitch              (pitch),
        .heading            (heading),
        .v_x                (v_x),
        .v_y                (v_y),
        .v_z                (v_z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_v(input string tag, input logic [31:0] ex,
                           input logic [31:0] ey, input logic [31:0] ez);
        check({tag, "_vx"}, v_x, ex);
        check({tag, "_vy"}, v_y, ey);
        check({tag, "_vz"}, v_z, ez);
    endtask

    // Raise request, count edges after the sampling edge until ready.
    task automatic run_req(input string tag, input logic [31:0] s,
                           input logic [31:0] p, input logic [31:0] hd);
        int cyc;
        @(negedge clk);
        speed   = s;
        pitch   = p;
        heading = hd;
        req     = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!ready && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd6);
    endtask

    task automatic drop_req(input string tag);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_rdy_low"}, 32'(ready), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_v("rst", 32'h0, 32'h0, 32'h0);
        check("rst_rdy", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        run_req("h0", 32'h0014_0000, 32'h0, 32'h0);
        check_v("h0", 32'h0, 32'h0, 32'hFFEC_0000);
        drop_req("h0");

        // Reset asserted while in MUL_Y wipes the committed outputs.
        @(negedge clk);
        speed   = 32'h0014_0000;
        pitch   = 32'h001E_0000;
        heading = 32'h005A_0000;
        req     = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_v("midrst", 32'h0, 32'h0, 32'h0);
        check("midrst_rdy", 32'(ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_idle", 32'(busy), 32'd0);
        @(negedge clk);
        req   = 1'b0;
        reset = 1'b1;

        run_req("h90", 32'h0014_0000, 32'h0, 32'h005A_0000);
        check_v("h90", 32'h0014_0000, 32'h0, 32'h0);
        drop_req("h90");

        run_req("p30", 32'h0014_0000, 32'h001E_0000, 32'h0);
        check_v("p30", 32'h0, 32'h000A_0000, 32'hFFEE_ADF0);
        drop_req("p30");

        run_req("pm30", 32'h0014_0000, 32'hFFE2_0000, 32'h0);
        check_v("pm30", 32'h0, 32'hFFF6_0000, 32'hFFEE_ADF0);
        drop_req("pm30");

        run_req("h360", 32'h0014_0000, 32'hFFE2_0000, 32'h0168_0000);
        check_v("h360", 32'h0, 32'hFFF6_0000, 32'hFFEE_ADF0);
        drop_req("h360");

        // Abort: request dropped in MUL_H, inputs changed mid-flight.
        @(negedge clk);
        speed   = 32'h0014_0000;
        pitch   = 32'h0;
        heading = 32'h005A_0000;
        req     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        req     = 1'b0;
        speed   = 32'h0005_0000;
        heading = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_v("abort_hold", 32'h0, 32'hFFF6_0000, 32'hFFEE_ADF0);
        check("abort_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check_v("abort", 32'h0014_0000, 32'h0, 32'h0);
        check("abort_rdy", 32'(ready), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_rdy", 32'(ready), 32'd0);
        end

        run_req("next", 32'h0005_0000, 32'h0, 32'h0);
        check_v("next", 32'h0, 32'h0, 32'hFFFB_0000);
        drop_req("next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
